// File: rtl/powlib_pkg.sv
// Shared types and helpers for the powlib read-stream initiator.
package powlib_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/powlib_dpram_rdstream_if.sv
// Control, RAM read port and output stream of the read-stream initiator.
interface powlib_dpram_rdstream_if #(
    parameter int W  = 32,
    parameter int AW = 2
);
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   len;
    logic          busy;
    logic          done;
    logic [AW-1:0] rdaddr;
    logic          rdvld;
    logic [W-1:0]  rddata;
    logic [W-1:0]  out_data;
    logic          out_vld;
    logic          out_rdy;

    // master is the surrounding system, slave is the initiator itself
    modport master (
        output start, base, len, rddata, out_rdy,
        input  busy, done, rdaddr, rdvld, out_data, out_vld
    );
    modport slave (
        input  start, base, len, rddata, out_rdy,
        output busy, done, rdaddr, rdvld, out_data, out_vld
    );
endinterface

// File: rtl/powlib_rdstream_buf.sv
// Small synchronous FIFO holding returned RAM words until the stream accepts them.
module powlib_rdstream_buf
    import powlib_pkg::*;
#(
    parameter int W     = 32,
    parameter int DEPTH = 2,
    parameter int CW    = clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [W-1:0]  wdata,
    input  logic          pop,
    output logic [W-1:0]  rdata,
    output logic          empty,
    output logic [CW-1:0] count
);
    localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam logic [PW-1:0] PLAST = PW'(DEPTH - 1);

    logic [DEPTH-1:0][W-1:0] mem;
    logic [PW-1:0]           wptr, rptr;

    // depth need not be a power of two, so pointers wrap explicitly
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PLAST) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem   <= '0;
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= nxt(wptr);
            end
            if (pop) rptr <= nxt(rptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rptr];
    assign empty = (count == '0);

endmodule

// File: rtl/powlib_dpram_rdstream.sv
// Streams a burst of sequential RAM words out as valid/ready data with credit-based flow control.
module powlib_dpram_rdstream
    import powlib_pkg::*;
#(
    parameter int W  = 32,
    parameter int D  = 4,
    parameter int AW = clog2(D),
    parameter int RL = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    powlib_dpram_rdstream_if.slave   bus
);
    localparam int DEPTH = RL + 1;
    localparam int CW    = clog2(DEPTH + 1);
    localparam logic [CW:0]   CREDITS = (CW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(D - 1);
    localparam logic [AW:0]   ONE     = 1;

    state_t          state, state_nxt;
    logic [AW-1:0]   addr;
    logic [AW:0]     iss_cnt, dlv_cnt;
    logic            done_q, done_nxt;
    logic [RL-1:0]   vld_pipe;
    logic [CW-1:0]   outst, occ;
    logic            empty, pop, credit, rdvld, accept;
    logic [W-1:0]    head;

    always_comb begin
        outst = '0;
        for (int i = 0; i < RL; i++) outst = outst + CW'(vld_pipe[i]);
    end

    // words in flight plus buffered, after this cycle's pop, must leave room for one more
    assign pop    = !empty && bus.out_rdy;
    assign credit = ({1'b0, outst} + {1'b0, occ}) < (CREDITS + {{CW{1'b0}}, pop});
    assign accept = (state == IDLE) && bus.start && (bus.len != '0);

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        rdvld     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0) done_nxt  = 1'b1;
                    else               state_nxt = RUN;
                end
            end
            RUN: begin
                rdvld = credit;
                if (credit && iss_cnt == ONE) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (pop && dlv_cnt == ONE) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr     <= '0;
            iss_cnt  <= '0;
            dlv_cnt  <= '0;
            vld_pipe <= '0;
        end else begin
            vld_pipe[0] <= rdvld;
            for (int i = 1; i < RL; i++) vld_pipe[i] <= vld_pipe[i-1];
            if (accept) begin
                addr    <= bus.base;
                iss_cnt <= bus.len;
                dlv_cnt <= bus.len;
            end else begin
                if (rdvld) begin
                    addr    <= (addr == LAST) ? '0 : addr + 1'b1;
                    iss_cnt <= iss_cnt - 1'b1;
                end
                if (pop) dlv_cnt <= dlv_cnt - 1'b1;
            end
        end
    end

    powlib_rdstream_buf #(
        .W     (W),
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (vld_pipe[RL-1]),
        .wdata (bus.rddata),
        .pop   (pop),
        .rdata (head),
        .empty (empty),
        .count (occ)
    );

    assign bus.busy     = (state != IDLE);
    assign bus.done     = done_q;
    assign bus.rdaddr   = addr;
    assign bus.rdvld    = rdvld;
    assign bus.out_vld  = !empty;
    assign bus.out_data = head;

endmodule
